sfx_mixer: RTL and testbench
============================

# sfx_mixer

Multi-channel sound-effect mixer that replaces the single-purpose gunshot player. It holds N_CH independent one-shot (optionally looping) voices, fetches their samples from one shared single-port sample ROM, applies per-channel attenuation, and sums them with saturation. It writes one mixed sample per frame into the audio codec write port, paced by the codec's write-ready. It sits between the game logic (trigger sources: shot, killed, gameover) and the audio codec.

## Interface
- N_CH, 4, number of voices (1..8)
- SAMPLE_W, 24, signed sample width (ROM data and codec data)
- ADDR_W, 15, sample ROM address width
- ATT_W, 3, per-channel attenuation shift width
- clk  in  1  system clock (CLOCK_50)
- reset_n  in  1  asynchronous, active-low reset
- trigger  in  N_CH  one-cycle start/restart request per channel
- ch_base  in  N_CH×ADDR_W  first ROM address of each channel's clip
- ch_len  in  N_CH×ADDR_W  clip length in samples; 0 = channel disabled
- ch_att  in  N_CH×ATT_W  arithmetic right-shift applied to channel sample
- ch_loop  in  N_CH  loop enable per channel (used only with SFX_MIXER_LOOP_EN)
- rom_addr  out  ADDR_W  shared ROM read address
- rom_data  in  SAMPLE_W  ROM data, valid exactly 1 cycle after rom_addr
- aud_write_ready  in  1  codec can accept a sample
- aud_write  out  1  one-cycle write strobe
- aud_write_d  out  SAMPLE_W  mixed sample, drives both codec channels
- busy  out  N_CH  channel currently playing

## Operation
- States: IDLE, FETCH, DRAIN, OUT.
- IDLE: when aud_write_ready=1, latch pending triggers (offset←0, active←1, pending←0; channels with ch_len=0 are not activated), clear accumulator, ch index←0, go FETCH.
- FETCH: cycle k (k=0..N_CH-1) drives rom_addr = ch_base[k]+offset[k] (mod 2^ADDR_W); the sample for channel k-1 is accumulated in the same cycle. After k=N_CH-1, go DRAIN.
- DRAIN: accumulate the last channel; go OUT.
- Accumulate: acc += active ? (rom_data >>> ch_att) : 0. acc width is SAMPLE_W+clog2(N_CH)+1 signed. A channel's active flag is sampled at its FETCH slot.
- Offset update at a channel's FETCH slot if active: offset==ch_len-1 → active←0 (or offset←0 when looping), else offset+1.
- OUT: aud_write_d ← acc saturated to signed SAMPLE_W range; aud_write=1 for one cycle; return to IDLE.
- trigger: sets pending[i] in any cycle, in any state. A trigger arriving mid-frame takes effect at the next frame start. Retrigger of an active channel restarts it at offset 0. A trigger in the same cycle as the IDLE→FETCH transition applies to that frame.
- busy = active.
- The same channel's samples are never fetched twice in one frame; all channels occupy their slot even when inactive (fixed latency).

## Timing
- Frame = N_CH+3 cycles from leaving IDLE to aud_write pulse (IDLE exit, N_CH FETCH, DRAIN, OUT).
- aud_write is registered; asserted only in OUT, regardless of aud_write_ready at that cycle. The codec FIFO absorbs it because ready was high at frame start.
- Minimum spacing between aud_write pulses is N_CH+3 cycles; real pacing comes from aud_write_ready.
- Reset (async assert, sync release): state IDLE, active=0, pending=0, offsets=0, acc=0, rom_addr=0, aud_write=0, aud_write_d=0, busy=0. Reset mid-frame aborts the frame with no write.

## Configuration
- SFX_MIXER_LOOP_EN defined: a channel with ch_loop=1 wraps its offset to 0 at the end of its clip and stays active until retriggered-while-ch_len=0 or reset.
- SFX_MIXER_LOOP_EN undefined: ch_loop is ignored; every clip is one-shot and deactivates after its last sample.

## Structure
- Package sfx_pkg: state enum typedef, SAMPLE_W/ADDR_W defaults, saturate function (acc → SAMPLE_W).
- Sub-module sfx_channel: per-channel pending/active/offset registers and end-of-clip/loop logic; instantiated N_CH times in a generate loop. The top handles the FSM, the ROM mux, and the accumulator.

## Test plan
- Reset with reset_n=0 mid-FETCH → aud_write=0, busy=0, rom_addr=0 at once; no write after release until ready.
- N_CH=4, ch0 base=100 len=3 att=0, ROM=addr value, trigger ch0, ready held 1 → three writes of 100,101,102, then 0s; busy[0] falls after the third fetch.
- Two channels at +0x7FFFFF each (att=0) → aud_write_d=0x7FFFFF (saturated); both at −0x800000 → 0x800000.
- ch1 att=2, sample 400 → output 100; att=7, sample −1 → output −1 (arithmetic shift).
- Trigger ch2 mid-frame → no contribution this frame, offset 0 next frame; retrigger while playing at offset 5 → restarts at 0.
- With SFX_MIXER_LOOP_EN, len=2, loop=1 → outputs base, base+1, base, ... continuously; without the macro → two samples then silence.

Source files
------------

// File: rtl/sfx_pkg.sv
// ---------------------------------------------------------------------------
// sfx_pkg
// Shared definitions for the sound-effect mixer:
//   - default widths for samples, ROM addresses, attenuation and voice count
//   - frame state machine encoding
//   - saturate(): clamps a sign-extended accumulator into a signed w-bit range
// ---------------------------------------------------------------------------
package sfx_pkg;

    localparam int DEF_N_CH     = 4;
    localparam int DEF_SAMPLE_W = 24;
    localparam int DEF_ADDR_W   = 15;
    localparam int DEF_ATT_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } sfx_state_t;

    // The accumulator is passed in sign-extended to 64 bits so one function
    // serves any parameterisation; callers truncate the result to w bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] acc,
                                                    input int w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        if (acc > max_v) begin
            saturate = max_v;
        end else if (acc < min_v) begin
            saturate = min_v;
        end else begin
            saturate = acc;
        end
    endfunction

endpackage

// File: rtl/sfx_channel.sv
// ---------------------------------------------------------------------------
// sfx_channel
// State for one mixer voice: pending trigger, active flag and clip offset.
//   clk, reset_n : clock, asynchronous active-low reset
//   trigger      : one-cycle start/restart request (accepted in any cycle)
//   start        : frame-start strobe from the mixer FSM
//   step         : this voice's FETCH slot is in the current cycle
//   len          : clip length in samples (0 = voice disabled)
//   loop_en      : wrap to offset 0 at end of clip instead of stopping
//   active       : voice is playing
//   offset       : current sample offset within the clip
// ---------------------------------------------------------------------------
module sfx_channel
    import sfx_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trigger,
    input  logic              start,
    input  logic              step,
    input  logic [ADDR_W-1:0] len,
    input  logic              loop_en,
    output logic              active,
    output logic [ADDR_W-1:0] offset
);

    logic pending;

    // A trigger coinciding with the frame-start strobe is consumed directly,
    // so it counts for the frame that is just beginning. A one-shot voice
    // keeps its final offset when it stops; the next start clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            active  <= 1'b0;
            offset  <= '0;
        end else if (start) begin
            pending <= 1'b0;
            if (pending || trigger) begin
                active <= (len != '0);
                offset <= '0;
            end
        end else begin
            if (trigger) begin
                pending <= 1'b1;
            end
            if (step && active) begin
                if (offset == len - ADDR_W'(1)) begin
                    if (loop_en) begin
                        offset <= '0;
                    end else begin
                        active <= 1'b0;
                    end
                end else begin
                    offset <= offset + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sfx_mixer.sv
// ---------------------------------------------------------------------------
// sfx_mixer
// N_CH-voice sound-effect mixer. Each frame fetches one sample per voice from
// a shared single-port ROM, attenuates it by an arithmetic right shift, sums
// the voices with saturation and emits one codec write.
//   clk, reset_n     : clock, asynchronous active-low reset
//   trigger          : per-voice one-cycle start/restart request
//   ch_base/ch_len   : per-voice clip base address and length (0 = disabled)
//   ch_att           : per-voice attenuation shift
//   ch_loop          : per-voice loop enable
//   rom_addr/rom_data: shared ROM port, data valid one cycle after address
//   aud_write_ready  : codec can accept a sample (checked at frame start)
//   aud_write        : one-cycle write strobe
//   aud_write_d      : mixed sample
//   busy             : per-voice active flags
// Configuration macro: SFX_MIXER_LOOP_EN enables ch_loop; without it every
// clip is one-shot and ch_loop is ignored.
// ---------------------------------------------------------------------------
module sfx_mixer
    import sfx_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ATT_W    = DEF_ATT_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_CH-1:0]            trigger,
    input  logic [N_CH*ADDR_W-1:0]     ch_base,
    input  logic [N_CH*ADDR_W-1:0]     ch_len,
    input  logic [N_CH*ATT_W-1:0]      ch_att,
    input  logic [N_CH-1:0]            ch_loop,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic signed [SAMPLE_W-1:0] rom_data,
    input  logic                       aud_write_ready,
    output logic                       aud_write,
    output logic [SAMPLE_W-1:0]        aud_write_d,
    output logic [N_CH-1:0]            busy
);

    localparam int ACC_W = SAMPLE_W + $clog2(N_CH) + 1;
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    sfx_state_t state;
    sfx_state_t state_next;

    logic [IDX_W-1:0]           idx;
    logic                       slot_valid;
    logic [ATT_W-1:0]           slot_att;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W-1:0]    contrib;
    logic signed [SAMPLE_W-1:0] shifted;
    logic signed [63:0]         acc_ext;

    logic                       frame_start;
    logic                       last_slot;
    logic [N_CH-1:0]            active;
    logic [N_CH-1:0]            step;
    logic [N_CH-1:0]            loop_sel;
    logic [ADDR_W-1:0]          offset [N_CH];

    assign frame_start = (state == IDLE) && aud_write_ready;
    assign last_slot   = (idx == IDX_W'(N_CH - 1));
    assign busy        = active;

`ifdef SFX_MIXER_LOOP_EN
    assign loop_sel = ch_loop;
`else
    logic unused_loop;
    assign loop_sel    = '0;
    assign unused_loop = ^ch_loop;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign step[i] = (state == FETCH) && (idx == IDX_W'(i));

        sfx_channel #(
            .ADDR_W (ADDR_W)
        ) u_channel (
            .clk     (clk),
            .reset_n (reset_n),
            .trigger (trigger[i]),
            .start   (frame_start),
            .step    (step[i]),
            .len     (ch_len[i*ADDR_W +: ADDR_W]),
            .loop_en (loop_sel[i]),
            .active  (active[i]),
            .offset  (offset[i])
        );
    end

    // Only FETCH drives a real address; every other state parks at 0, which
    // also gives rom_addr=0 immediately under reset.
    always_comb begin
        rom_addr = '0;
        if (state == FETCH) begin
            rom_addr = ch_base[idx*ADDR_W +: ADDR_W] + offset[idx];
        end
    end

    // The ROM answers one cycle late, so the sample arriving now belongs to
    // the previous slot; its active flag and shift were captured then.
    always_comb begin
        shifted  = rom_data >>> slot_att;
        contrib  = {{(ACC_W - SAMPLE_W){shifted[SAMPLE_W-1]}}, shifted};
        acc_next = slot_valid ? (acc + contrib) : acc;
        acc_ext  = {{(64 - ACC_W){acc_next[ACC_W-1]}}, acc_next};
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: the frame length is fixed regardless of which voices
    // are active.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (aud_write_ready) state_next = FETCH;
            FETCH:   if (last_slot)       state_next = DRAIN;
            DRAIN:   state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath. The final sum is saturated straight from acc_next in DRAIN so
    // that the registered strobe and data are both valid during OUT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx         <= '0;
            slot_valid  <= 1'b0;
            slot_att    <= '0;
            acc         <= '0;
            aud_write   <= 1'b0;
            aud_write_d <= '0;
        end else begin
            aud_write <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (aud_write_ready) begin
                        idx        <= '0;
                        slot_valid <= 1'b0;
                        acc        <= '0;
                    end
                end
                FETCH: begin
                    acc        <= acc_next;
                    slot_valid <= active[idx];
                    slot_att   <= ch_att[idx*ATT_W +: ATT_W];
                    if (!last_slot) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    acc         <= acc_next;
                    slot_valid  <= 1'b0;
                    aud_write   <= 1'b1;
                    aud_write_d <= SAMPLE_W'(saturate(acc_ext, SAMPLE_W));
                end
                OUT: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfx_mixer.sv
// ---------------------------------------------------------------------------
// tb_sfx_mixer
// Directed bench for sfx_mixer with default parameters (4 voices, 24-bit
// samples, 15-bit addresses). The ROM model returns its own address unless a
// scenario overwrites an entry. Loop expectations follow SFX_MIXER_LOOP_EN.
// ---------------------------------------------------------------------------
module tb_sfx_mixer;

`ifdef SFX_MIXER_LOOP_EN
    localparam bit LOOP_BUILD = 1'b1;
`else
    localparam bit LOOP_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  trigger;
    logic [59:0] ch_base;
    logic [59:0] ch_len;
    logic [11:0] ch_att;
    logic [3:0]  ch_loop;
    logic [14:0] rom_addr;
    logic [23:0] rom_data;
    logic        aud_write_ready;
    logic        aud_write;
    logic [23:0] aud_write_d;
    logic [3:0]  busy;

    logic [23:0] rom [0:32767];

    int checks   = 0;
    int failures = 0;

    sfx_mixer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .trigger         (trigger),
        .ch_base         (ch_base),
        .ch_len          (ch_len),
        .ch_att          (ch_att),
        .ch_loop         (ch_loop),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .aud_write_ready (aud_write_ready),
        .aud_write       (aud_write),
        .aud_write_d     (aud_write_d),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data one cycle after the address.
    always @(posedge clk) begin
        rom_data <= rom[rom_addr];
    end

    task automatic set_ch(input int ch, input int base, input int len,
                          input int att, input bit lp);
        ch_base[ch*15 +: 15] = 15'(base);
        ch_len[ch*15 +: 15]  = 15'(len);
        ch_att[ch*3 +: 3]    = 3'(att);
        ch_loop[ch]          = lp;
    endtask

    task automatic do_reset;
        reset_n         = 1'b0;
        trigger         = '0;
        aud_write_ready = 1'b0;
        ch_base         = '0;
        ch_len          = '0;
        ch_att          = '0;
        ch_loop         = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Lets any running frame finish with ready low, then raises ready together
    // with the trigger mask so the triggers apply to the frame that starts.
    // Returns at the negedge inside the first FETCH slot.
    task automatic apply_stimulus(input logic [3:0] mask);
        aud_write_ready = 1'b0;
        trigger         = '0;
        repeat (10) @(negedge clk);
        trigger         = mask;
        aud_write_ready = 1'b1;
        @(negedge clk);
        trigger = '0;
    endtask

    // Waits (bounded) for the next write; n is the number of negedges waited,
    // or -1 if no write appeared.
    task automatic get_write(output logic [23:0] d, output int n);
        d = '0;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (aud_write) begin
                d = aud_write_d;
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int writes;
        do_reset;
        checks++;
        if (aud_write !== 1'b0 || busy !== 4'b0000 || rom_addr !== 15'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: got write=%b busy=%b addr=%0d, expected 0 0 0",
                     aud_write, busy, rom_addr);
        end
        set_ch(0, 100, 3, 0, 1'b0);
        apply_stimulus(4'b0001);
        checks++;
        if (rom_addr !== 15'd100) begin
            failures++;
            $display("[TB] FAIL fetch_addr_ch0: got %0d expected 100", rom_addr);
        end
        checks++;
        if (busy !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL busy_after_trigger: got %b expected 0001", busy);
        end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (aud_write !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midframe_reset_write: got %b expected 0", aud_write);
        end
        checks++;
        if (busy !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL midframe_reset_busy: got %b expected 0000", busy);
        end
        checks++;
        if (rom_addr !== 15'd0) begin
            failures++;
            $display("[TB] FAIL midframe_reset_addr: got %0d expected 0", rom_addr);
        end
        aud_write_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        writes  = 0;
        repeat (20) begin
            @(negedge clk);
            if (aud_write) writes++;
        end
        checks++;
        if (writes !== 0) begin
            failures++;
            $display("[TB] FAIL no_write_without_ready: got %0d writes expected 0", writes);
        end
    endtask

    task automatic test_oneshot;
        logic [23:0] d;
        int          n;
        logic [23:0] exp_v [4];
        exp_v = '{24'd101, 24'd102, 24'd0, 24'd0};
        do_reset;
        set_ch(0, 100, 3, 0, 1'b0);
        apply_stimulus(4'b0001);
        get_write(d, n);
        checks++;
        if (n !== 5 || d !== 24'd100) begin
            failures++;
            $display("[TB] FAIL oneshot_first: got d=%0d after %0d, expected 100 after 5", d, n);
        end
        checks++;
        if (busy !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL oneshot_busy_playing: got %b expected 0001", busy);
        end
        for (int i = 0; i < 4; i++) begin
            get_write(d, n);
            checks++;
            if (d !== exp_v[i]) begin
                failures++;
                $display("[TB] FAIL oneshot_sample%0d: got %0d expected %0d", i + 1, d, exp_v[i]);
            end
            checks++;
            if (n !== 7) begin
                failures++;
                $display("[TB] FAIL frame_spacing%0d: got %0d cycles expected 7", i + 1, n);
            end
            if (i == 1) begin
                checks++;
                if (busy !== 4'b0000) begin
                    failures++;
                    $display("[TB] FAIL oneshot_busy_end: got %b expected 0000", busy);
                end
            end
        end
    endtask

    task automatic test_saturation;
        logic [23:0] d;
        int          n;
        do_reset;
        set_ch(0, 200, 1, 0, 1'b0);
        set_ch(1, 300, 1, 0, 1'b0);
        rom[200] = 24'h7FFFFF;
        rom[300] = 24'h7FFFFF;
        apply_stimulus(4'b0011);
        get_write(d, n);
        checks++;
        if (n < 0 || d !== 24'h7FFFFF) begin
            failures++;
            $display("[TB] FAIL sat_positive: got %h expected 7fffff", d);
        end
        rom[200] = 24'h800000;
        rom[300] = 24'h800000;
        apply_stimulus(4'b0011);
        get_write(d, n);
        checks++;
        if (n < 0 || d !== 24'h800000) begin
            failures++;
            $display("[TB] FAIL sat_negative: got %h expected 800000", d);
        end
        rom[200] = 24'h7FFFFF;
        rom[300] = 24'hFFFFFF;
        apply_stimulus(4'b0011);
        get_write(d, n);
        checks++;
        if (n < 0 || d !== 24'h7FFFFE) begin
            failures++;
            $display("[TB] FAIL sat_near_max: got %h expected 7ffffe", d);
        end
        rom[200] = 24'd1000;
        rom[300] = 24'hFFFED4;
        rom[400] = 24'd7;
        set_ch(2, 400, 1, 0, 1'b0);
        apply_stimulus(4'b0111);
        get_write(d, n);
        checks++;
        if (n < 0 || d !== 24'd707) begin
            failures++;
            $display("[TB] FAIL three_voice_sum: got %0d expected 707", d);
        end
        rom[200] = 24'd200;
        rom[300] = 24'd300;
        rom[400] = 24'd400;
    endtask

    task automatic test_attenuation;
        logic [23:0] d;
        int          n;
        do_reset;
        rom[500] = 24'd400;
        set_ch(1, 500, 1, 2, 1'b0);
        apply_stimulus(4'b0010);
        get_write(d, n);
        checks++;
        if (n < 0 || d !== 24'd100) begin
            failures++;
            $display("[TB] FAIL att2_positive: got %0d expected 100", d);
        end
        rom[500] = 24'hFFFFFF;
        set_ch(1, 500, 1, 7, 1'b0);
        apply_stimulus(4'b0010);
        get_write(d, n);
        checks++;
        if (n < 0 || d !== 24'hFFFFFF) begin
            failures++;
            $display("[TB] FAIL att7_minus_one: got %h expected ffffff", d);
        end
        rom[500] = 24'hFFFFF7;
        set_ch(1, 500, 1, 3, 1'b0);
        apply_stimulus(4'b0010);
        get_write(d, n);
        checks++;
        if (n < 0 || d !== 24'hFFFFFE) begin
            failures++;
            $display("[TB] FAIL att3_minus_nine: got %h expected fffffe", d);
        end
        rom[500] = 24'd500;
    endtask

    task automatic test_mid_frame_trigger;
        logic [23:0] d;
        int          n;
        do_reset;
        set_ch(0, 100, 3, 0, 1'b0);
        set_ch(2, 1000, 4, 0, 1'b0);
        apply_stimulus(4'b0001);
        @(negedge clk);
        trigger = 4'b0100;
        @(negedge clk);
        trigger = '0;
        get_write(d, n);
        checks++;
        if (n < 0 || d !== 24'd100) begin
            failures++;
            $display("[TB] FAIL midframe_no_contrib: got %0d expected 100", d);
        end
        checks++;
        if (busy !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL midframe_busy_pending: got %b expected 0001", busy);
        end
        get_write(d, n);
        checks++;
        if (n < 0 || d !== 24'd1101) begin
            failures++;
            $display("[TB] FAIL midframe_next_frame: got %0d expected 1101", d);
        end
        checks++;
        if (busy !== 4'b0101) begin
            failures++;
            $display("[TB] FAIL midframe_busy_both: got %b expected 0101", busy);
        end
    endtask

    task automatic test_back_to_back_retrigger;
        logic [23:0] d;
        int          n;
        logic [23:0] exp_v [3];
        exp_v = '{24'd1005, 24'd1000, 24'd1001};
        do_reset;
        set_ch(2, 1000, 10, 0, 1'b0);
        apply_stimulus(4'b0100);
        for (int i = 0; i < 5; i++) begin
            get_write(d, n);
            checks++;
            if (n < 0 || d !== 24'(1000 + i)) begin
                failures++;
                $display("[TB] FAIL play_offset%0d: got %0d expected %0d", i, d, 1000 + i);
            end
        end
        @(negedge clk);
        @(negedge clk);
        trigger = 4'b0100;
        @(negedge clk);
        trigger = '0;
        for (int i = 0; i < 3; i++) begin
            get_write(d, n);
            checks++;
            if (n < 0 || d !== exp_v[i]) begin
                failures++;
                $display("[TB] FAIL retrigger%0d: got %0d expected %0d", i, d, exp_v[i]);
            end
        end
    endtask

    task automatic test_loop;
        logic [23:0] d;
        int          n;
        logic [23:0] exp_v [5];
        logic [3:0]  exp_busy;
        if (LOOP_BUILD) begin
            exp_v    = '{24'd2000, 24'd2001, 24'd2000, 24'd2001, 24'd2000};
            exp_busy = 4'b1000;
        end else begin
            exp_v    = '{24'd2000, 24'd2001, 24'd0, 24'd0, 24'd0};
            exp_busy = 4'b0000;
        end
        do_reset;
        set_ch(3, 2000, 2, 0, 1'b1);
        apply_stimulus(4'b1000);
        for (int i = 0; i < 5; i++) begin
            get_write(d, n);
            checks++;
            if (n < 0 || d !== exp_v[i]) begin
                failures++;
                $display("[TB] FAIL loop_sample%0d: got %0d expected %0d", i, d, exp_v[i]);
            end
        end
        checks++;
        if (busy !== exp_busy) begin
            failures++;
            $display("[TB] FAIL loop_busy: got %b expected %b", busy, exp_busy);
        end
        set_ch(3, 2000, 0, 0, 1'b1);
        @(negedge clk);
        trigger = 4'b1000;
        @(negedge clk);
        trigger = '0;
        get_write(d, n);
        checks++;
        if (n < 0 || d !== 24'd0) begin
            failures++;
            $display("[TB] FAIL len_zero_stop: got %0d expected 0", d);
        end
        checks++;
        if (busy !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL len_zero_busy: got %b expected 0000", busy);
        end
    endtask

    initial begin
        reset_n         = 1'b0;
        trigger         = '0;
        aud_write_ready = 1'b0;
        ch_base         = '0;
        ch_len          = '0;
        ch_att          = '0;
        ch_loop         = '0;
        for (int i = 0; i < 32768; i++) begin
            rom[i] = 24'(i);
        end
        test_reset;
        test_oneshot;
        test_saturation;
        test_attenuation;
        test_mid_frame_trigger;
        test_back_to_back_retrigger;
        test_loop;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
